// File: rtl/rob_pkg.sv
// Shared ROB entry layout and retirement state encoding; used by both the
// ROB enqueue side and the retirement stage.
package rob_pkg;

  localparam int ENTRY_WIDTH = 73;

  localparam int DONE_BIT     = 0;
  localparam int HAS_DEST_BIT = 1;
  localparam int RD_LSB       = 2;
  localparam int RD_MSB       = 6;
  localparam int RESULT_LSB   = 7;
  localparam int RESULT_MSB   = 38;
  localparam int MISPRED_BIT  = 39;
  localparam int TARGET_LSB   = 40;
  localparam int TARGET_MSB   = 71;
  localparam int EXC_BIT      = 72;

  // Declared MSB first so the packed layout matches the bit constants above.
  typedef struct packed {
    logic        exception;
    logic [31:0] target;
    logic        mispredict;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        has_dest;
    logic        done;
  } rob_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } retire_state_t;

endpackage

// File: rtl/retire_flush_timer.sv
// Down-counter that holds retirement off for FLUSH_CYCLES cycles after a flush.
module retire_flush_timer #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(FLUSH_CYCLES);
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // Expire on the last blocked cycle so RUN resumes exactly FLUSH_CYCLES later.
  assign expire = dec && (count == 4'd1);

endmodule

// File: rtl/rob_retire.sv
// In-order retirement stage behind the ROB head: ARF commit, mispredict flush,
// exception halt. Optional instret counter enabled by ROB_RETIRE_INSTRET_EN.
module rob_retire
  import rob_pkg::*;
#(
  parameter int PTR_WIDTH    = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   deq_valid,
  input  logic [ENTRY_WIDTH-1:0] deq_data,
  input  logic [PTR_WIDTH-1:0]   deq_addr,
  output logic                   deq_ready,
  output logic                   arf_we,
  output logic [4:0]             arf_addr,
  output logic [31:0]            arf_data,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   exc_valid,
  output logic [PTR_WIDTH-1:0]   exc_rob_id,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   instret
);

  rob_entry_t    entry;
  retire_state_t state, state_next;
  logic          retire_p0, retire_ok_p0, retire_mis_p0, retire_exc_p0;
  logic          flush_expire;

  assign entry = deq_data;

  assign deq_ready     = (state == RUN) & deq_valid & entry.done & ~rst;
  assign retire_p0     = deq_valid & deq_ready;
  assign retire_exc_p0 = retire_p0 & entry.exception;
  assign retire_ok_p0  = retire_p0 & ~entry.exception;
  assign retire_mis_p0 = retire_ok_p0 & entry.mispredict;

  retire_flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (retire_mis_p0),
    .dec   (state == FLUSH),
    .expire(flush_expire)
  );

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (retire_exc_p0)      state_next = HALT;
        else if (retire_mis_p0) state_next = FLUSH;
      end
      FLUSH:   if (flush_expire) state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Stage p0 -> p1: every architectural side effect is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      arf_we         <= 1'b0;
      arf_addr       <= '0;
      arf_data       <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      exc_valid      <= 1'b0;
      exc_rob_id     <= '0;
      halted         <= 1'b0;
    end else begin
      state          <= state_next;
      arf_we         <= retire_ok_p0 & entry.has_dest & (entry.rd != 5'd0);
      flush          <= retire_mis_p0;
      redirect_valid <= retire_mis_p0;
      exc_valid      <= retire_exc_p0;
      if (retire_ok_p0) begin
        arf_addr <= entry.rd;
        arf_data <= entry.result;
      end
      if (retire_mis_p0) redirect_pc <= entry.target;
      if (retire_exc_p0) begin
        exc_rob_id <= deq_addr;
        halted     <= 1'b1;
      end
    end
  end

`ifdef ROB_RETIRE_INSTRET_EN
  always_ff @(posedge clk) begin
    if (rst)               instret <= '0;
    else if (retire_ok_p0) instret <= instret + 1'b1;
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: normal, back-to-back, stall, mispredict,
// exception and reset-during-flush cases with hand-computed expectations.
module tb_rob_retire;

  logic        clk = 1'b0;
  logic        rst;
  logic        deq_valid;
  logic [72:0] deq_data;
  logic [2:0]  deq_addr;
  logic        deq_ready;
  logic        arf_we;
  logic [4:0]  arf_addr;
  logic [31:0] arf_data;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic [2:0]  exc_rob_id;
  logic        halted;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  rob_retire #(
    .PTR_WIDTH(3), .FLUSH_CYCLES(2), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .deq_valid(deq_valid), .deq_data(deq_data),
    .deq_addr(deq_addr), .deq_ready(deq_ready), .arf_we(arf_we),
    .arf_addr(arf_addr), .arf_data(arf_data), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .exc_rob_id(exc_rob_id), .halted(halted),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] mk(input logic done, input logic has_dest, input logic [4:0] rd,
                                     input logic [31:0] result, input logic mis,
                                     input logic [31:0] target, input logic exc);
    return {exc, target, mis, result, rd, has_dest, done};
  endfunction

  function automatic logic [63:0] ie(input int n);
`ifdef ROB_RETIRE_INSTRET_EN
    return 64'(n);
`else
    return 64'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle the combinational deq_ready after driving inputs.
  task automatic settle();
    #2;
  endtask

  logic [4:0]  b2b_rd  [3] = '{5'd3, 5'd0, 5'd7};
  logic [31:0] b2b_res [3] = '{32'h1, 32'h2, 32'h3};
  logic        b2b_we  [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    deq_valid = 1'b1;
    deq_addr = 3'd0;
    deq_data = mk(1, 1, 5'd1, 32'h11, 0, 32'h0, 0);
    step();
    step();
    check("rst_ready", deq_ready, 0);
    check("rst_arf_we", arf_we, 0);
    check("rst_flush", flush, 0);
    check("rst_halted", halted, 0);
    check("rst_exc", exc_valid, 0);
    check("rst_instret", instret, 0);

    // Normal retire
    rst = 1'b0;
    deq_data = mk(1, 1, 5'd5, 32'hDEADBEEF, 0, 32'h0, 0);
    settle();
    check("norm_ready", deq_ready, 1);
    step();
    deq_valid = 1'b0;
    check("norm_we", arf_we, 1);
    check("norm_addr", arf_addr, 5);
    check("norm_data", arf_data, 32'hDEADBEEF);
    check("norm_instret", instret, ie(1));
    step();
    check("idle_we", arf_we, 0);

    // Back-to-back with rd==0 in the middle
    deq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      deq_data = mk(1, 1, b2b_rd[i], b2b_res[i], 0, 32'h0, 0);
      settle();
      check("b2b_ready", deq_ready, 1);
      step();
      check("b2b_we", arf_we, b2b_we[i]);
      if (b2b_we[i]) check("b2b_data", arf_data, b2b_res[i]);
    end
    deq_valid = 1'b0;
    check("b2b_addr", arf_addr, 7);
    check("b2b_instret", instret, ie(4));

    // Head not done for 4 cycles
    deq_valid = 1'b1;
    deq_data = mk(0, 1, 5'd9, 32'h99, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("nd_ready", deq_ready, 0);
      step();
      check("nd_we", arf_we, 0);
    end
    deq_data = mk(1, 1, 5'd9, 32'h99, 0, 32'h0, 0);
    settle();
    check("nd_ready_go", deq_ready, 1);
    step();
    deq_valid = 1'b0;
    check("nd_we_go", arf_we, 1);
    check("nd_addr", arf_addr, 9);
    check("nd_instret", instret, ie(5));

    // Mispredict with the next entry already waiting
    deq_valid = 1'b1;
    deq_data = mk(1, 1, 5'd4, 32'h44, 1, 32'h80000040, 0);
    settle();
    check("mis_ready", deq_ready, 1);
    step();
    deq_data = mk(1, 1, 5'd6, 32'h66, 0, 32'h0, 0);
    check("mis_flush", flush, 1);
    check("mis_redir", redirect_valid, 1);
    check("mis_pc", redirect_pc, 32'h80000040);
    check("mis_we", arf_we, 1);
    check("mis_instret", instret, ie(6));
    settle();
    check("mis_block1", deq_ready, 0);
    step();
    check("mis_flush_off", flush, 0);
    check("mis_redir_off", redirect_valid, 0);
    settle();
    check("mis_block2", deq_ready, 0);
    step();
    settle();
    check("mis_resume", deq_ready, 1);
    step();
    check("mis_next_we", arf_we, 1);
    check("mis_next_addr", arf_addr, 6);
    check("mis_next_instret", instret, ie(7));

    // Exception with mispredict also set at ROB index 6
    deq_addr = 3'd6;
    deq_data = mk(1, 1, 5'd8, 32'h88, 1, 32'h12345678, 1);
    settle();
    check("exc_ready", deq_ready, 1);
    step();
    deq_addr = 3'd7;
    deq_data = mk(1, 1, 5'd10, 32'hAA, 0, 32'h0, 0);
    check("exc_valid", exc_valid, 1);
    check("exc_id", exc_rob_id, 6);
    check("exc_halted", halted, 1);
    check("exc_we", arf_we, 0);
    check("exc_noflush", flush, 0);
    check("exc_instret", instret, ie(7));
    for (int i = 0; i < 10; i++) begin
      settle();
      check("halt_ready", deq_ready, 0);
      step();
      check("halt_exc_off", exc_valid, 0);
    end
    check("halt_sticky", halted, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("exc_rst_halted", halted, 0);
    check("exc_rst_instret", instret, 0);
    settle();
    check("exc_rst_ready", deq_ready, 1);
    step();
    check("exc_rst_we", arf_we, 1);
    check("exc_rst_addr", arf_addr, 10);
    check("exc_rst_inst", instret, ie(1));

    // Reset during FLUSH
    deq_data = mk(1, 0, 5'd0, 32'h0, 1, 32'hCAFE0000, 0);
    step();
    check("rf_flush", flush, 1);
    rst = 1'b1;
    deq_data = mk(1, 1, 5'd3, 32'h33, 0, 32'h0, 0);
    settle();
    check("rf_ready_rst", deq_ready, 0);
    step();
    rst = 1'b0;
    check("rf_flush0", flush, 0);
    check("rf_redir0", redirect_valid, 0);
    check("rf_pc0", redirect_pc, 0);
    check("rf_we0", arf_we, 0);
    check("rf_instret0", instret, 0);
    settle();
    check("rf_run_ready", deq_ready, 1);
    step();
    deq_valid = 1'b0;
    check("rf_we_after", arf_we, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
